fp_flags_ctrl: RTL and testbench
================================

Name: fp_flags_ctrl

Overview:
- Sticky FP exception-flag controller for the FPU datapath.
- Arbitrates flag postings from two FP execution units (add/sub, mul) onto one 4-bit sticky flag register.
- Services masked read-and-clear requests from the control interface.
- Raises an acknowledged interrupt when an enabled flag is set, and counts flag-raising events.

Parameters:
- FLAG_W, 4, flag vector width. Bit order is fixed: [0] invalid, [1] overflow, [2] underflow, [3] inexact.
- CNT_W, 8, width of the saturating event counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester flag post valid (bit 0 = add unit, bit 1 = mul unit).
- req_flags0  input  FLAG_W  flags posted by requester 0.
- req_flags1  input  FLAG_W  flags posted by requester 1.
- req_ready  output  2  per-requester grant; combinational.
- clr_valid  input  1  clear request.
- clr_mask  input  FLAG_W  bits to clear.
- clr_ready  output  1  clear accept.
- irq_en  input  FLAG_W  interrupt enable mask.
- irq_ack  input  1  interrupt acknowledge pulse.
- flags  output  FLAG_W  sticky flag register.
- irq  output  1  interrupt request.
- evt_cnt  output  CNT_W  count of accepted posts with nonzero flags.

Behaviour:
- Reset (async, reset_n=0):
  - flags=0, evt_cnt=0, irq=0, FSM=IDLE, rr_ptr=0, clr_ready=0, req_ready=0.
  - Reset asserted mid-operation discards any in-flight post or clear immediately.
- Arbitration:
  - A post is accepted when req_valid[i] && req_ready[i]. At most one post is accepted per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester at rr_ptr is granted; the other sees ready=0 and must hold valid and flags stable.
  - rr_ptr toggles to the non-granted index only on a contended grant.
  - req_ready is 0 for any requester whose valid is 0.
- Flag update, 1-cycle latency:
  - flags_next = (flags & ~(clr_acc ? clr_mask : 0)) | acc_flags, where acc_flags is the accepted post's flags, or 0 if no post was accepted.
  - When clear and set target the same bit in the same cycle, set wins.
- Clear handshake:
  - clr_ready=1 whenever out of reset.
  - A clear is accepted on clr_valid && clr_ready.
  - clr_mask=0 is a legal no-op.
- Event counter:
  - Increments by 1 on an accepted post with acc_flags != 0.
  - Saturates at 2^CNT_W-1.
  - Is not cleared by clr; it is cleared only by reset.
- Interrupt FSM (irq is a registered output):
  - Define pend = |(flags & irq_en), evaluated on the registered flags.
  - IDLE: irq=0. If pend, go to ACTIVE.
  - ACTIVE: irq=1. On irq_ack, go to ACKED.
  - ACKED: irq=0. If !pend, go to IDLE. If new masked bits become set that were not set at ack time, go to ACTIVE (tracked via an ack-time snapshot of flags & irq_en).
  - irq_ack outside ACTIVE is ignored.
  - Changing irq_en to 0 while in ACTIVE: the FSM stays in ACTIVE until acked. Note: no spurious drop.
- Timing from post to interrupt:
  - A post accepted at cycle N is visible on flags at N+1.
  - irq rises at N+2 when the bit is enabled.

Test Plan:
- Single post: reset, then req_valid=01, req_flags0=0010 for one cycle -> req_ready=01; flags=0010 next cycle; evt_cnt=1.
- Contention: req_valid=11 held with flags0=0001, flags1=1000 -> grants in order 0 then 1 (rr_ptr starts at 0); flags=1001 after 2 cycles; evt_cnt=2; no cycle with req_ready=11.
- Set beats clear: flags=0110; same cycle accept post 0100 and clear mask 0110 -> flags=0100.
- Interrupt: irq_en=0010, post 0010 at cycle N -> irq=1 at N+2.
  - irq_ack -> irq=0 next cycle, FSM in ACKED.
  - Clear 0010 -> FSM returns to IDLE.
  - Then post 0010 again -> irq re-asserts.
- Saturation: with CNT_W=8, issue 300 nonzero posts -> evt_cnt=255. A post with flags 0000 leaves the counter unchanged.
- Reset mid-operation: assert reset_n=0 while req_valid=11 and irq=1 -> flags=0, irq=0, evt_cnt=0, and all ready signals 0 asynchronously. After release, the first contended grant goes to requester 0.

Source files
------------

// File: rtl/fp_flags_ctrl_if.sv
// fp_flags_ctrl_if: flag-post, clear and interrupt signals between the FPU units and the sticky flag controller
interface fp_flags_ctrl_if #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 8
);
  logic [1:0]        req_valid;
  logic [FLAG_W-1:0] req_flags0;
  logic [FLAG_W-1:0] req_flags1;
  logic [1:0]        req_ready;
  logic              clr_valid;
  logic [FLAG_W-1:0] clr_mask;
  logic              clr_ready;
  logic [FLAG_W-1:0] irq_en;
  logic              irq_ack;
  logic [FLAG_W-1:0] flags;
  logic              irq;
  logic [CNT_W-1:0]  evt_cnt;
  modport master (
    output req_valid, req_flags0, req_flags1, clr_valid, clr_mask, irq_en, irq_ack,
    input  req_ready, clr_ready, flags, irq, evt_cnt
  );
  modport slave (
    input  req_valid, req_flags0, req_flags1, clr_valid, clr_mask, irq_en, irq_ack,
    output req_ready, clr_ready, flags, irq, evt_cnt
  );
endinterface

// File: rtl/fp_flags_ctrl.sv
// fp_flags_ctrl: sticky FP exception flags with round-robin post arbitration,
// masked clear, acknowledged interrupt and a saturating event counter
module fp_flags_ctrl #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           reset_n,
  fp_flags_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ACKED} state_t;
  state_t            r_state, w_next;
  logic              r_rr;
  logic [FLAG_W-1:0] r_flags, r_snap, w_acc, w_clr, w_masked;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_grant;
  logic              w_both, w_pend, w_new;
  // Ready is gated by reset_n directly so grants vanish asynchronously with reset
  assign w_both   = &bus.req_valid;
  assign w_grant  = !reset_n ? 2'b00 : w_both ? (r_rr ? 2'b10 : 2'b01) : bus.req_valid;
  assign w_acc    = w_grant[0] ? bus.req_flags0 : w_grant[1] ? bus.req_flags1 : '0;
  assign w_clr    = (bus.clr_valid && bus.clr_ready) ? bus.clr_mask : '0;
  assign w_masked = r_flags & bus.irq_en;
  assign w_pend   = |w_masked;
  assign w_new    = |(w_masked & ~r_snap);
  assign bus.req_ready = w_grant;
  assign bus.clr_ready = reset_n;
  assign bus.flags     = r_flags;
  assign bus.evt_cnt   = r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_flags <= '0;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_snap  <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clr) | w_acc;
      if (|w_grant && |w_acc && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      if (w_both) r_rr <= ~r_rr;
      if (r_state == ACTIVE && bus.irq_ack) r_snap <= w_masked;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // ACKED re-arms only on masked bits that were not already set at ack time
  always_comb
    w_next = r_state == IDLE   ? (w_pend ? ACTIVE : IDLE) :
             r_state == ACTIVE ? (bus.irq_ack ? ACKED : ACTIVE) :
             w_new ? ACTIVE : w_pend ? ACKED : IDLE;
  always_comb
    bus.irq = (r_state == ACTIVE);
endmodule

// File: tb/tb_fp_flags_ctrl.sv
// tb_fp_flags_ctrl: scoreboard bench; a cycle model pushes expected state at drive time, popped after the edge
module tb_fp_flags_ctrl;
  typedef struct {logic [3:0] f; logic irq; logic [7:0] cnt;} exp_t;
  logic clk = 0, reset_n = 0;
  int n_chk = 0, n_err = 0;
  exp_t q[$];
  logic [3:0] m_flags, m_snap;
  logic [7:0] m_cnt;
  logic       m_rr;
  int         m_state;
  fp_flags_ctrl_if #(.FLAG_W(4), .CNT_W(8)) bus();
  fp_flags_ctrl #(.FLAG_W(4), .CNT_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_flags = 0; m_snap = 0; m_cnt = 0; m_rr = 0; m_state = 0;
    q.delete();
  endtask
  task automatic step();
    logic [1:0] g;
    logic [3:0] acc, pm;
    int ns;
    exp_t e;
    #1;
    g = (bus.req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : bus.req_valid;
    chk("req_ready", bus.req_ready, g);
    chk("clr_ready", bus.clr_ready, 1);
    acc = g[0] ? bus.req_flags0 : g[1] ? bus.req_flags1 : 4'h0;
    pm = m_flags & bus.irq_en;
    ns = m_state;
    if (m_state == 0) ns = (pm != 0) ? 1 : 0;
    else if (m_state == 1) begin
      if (bus.irq_ack) begin ns = 2; m_snap = pm; end
    end else ns = ((pm & ~m_snap) != 0) ? 1 : (pm != 0) ? 2 : 0;
    m_state = ns;
    if (bus.req_valid == 2'b11) m_rr = ~m_rr;
    if (g != 0 && acc != 0 && m_cnt != 8'hff) m_cnt++;
    m_flags = (m_flags & ~(bus.clr_valid ? bus.clr_mask : 4'h0)) | acc;
    e.f = m_flags; e.irq = (m_state == 1); e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("flags", bus.flags, e.f);
    chk("irq", bus.irq, e.irq);
    chk("evt_cnt", bus.evt_cnt, e.cnt);
  endtask
  task automatic idle();
    bus.req_valid = 0; bus.clr_valid = 0; bus.clr_mask = 0; bus.irq_ack = 0;
  endtask
  initial begin
    idle();
    bus.req_flags0 = 0; bus.req_flags1 = 0; bus.irq_en = 0;
    m_reset();
    bus.req_valid = 2'b11;
    #2;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_clr_ready", bus.clr_ready, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_cnt", bus.evt_cnt, 0);
    idle();
    @(negedge clk); reset_n = 1;
    // single post
    bus.req_valid = 2'b01; bus.req_flags0 = 4'b0010; step();
    idle(); step();
    chk("single_flags", bus.flags, 4'b0010);
    chk("single_cnt", bus.evt_cnt, 1);
    // contention, requester 0 first
    bus.req_valid = 2'b11; bus.req_flags0 = 4'b0001; bus.req_flags1 = 4'b1000; step();
    chk("cont_g0", bus.req_ready, 2'b10);
    bus.req_valid = 2'b10; step();
    idle(); step();
    chk("cont_flags", bus.flags, 4'b1011);
    chk("cont_cnt", bus.evt_cnt, 3);
    // set beats clear
    bus.clr_valid = 1; bus.clr_mask = 4'hf; step();
    idle(); bus.req_valid = 2'b01; bus.req_flags0 = 4'b0110; step();
    bus.req_flags0 = 4'b0100; bus.clr_valid = 1; bus.clr_mask = 4'b0110; step();
    chk("set_wins", bus.flags, 4'b0100);
    bus.clr_mask = 4'b0000; bus.req_valid = 0; step();
    // interrupt flow
    idle(); bus.clr_valid = 1; bus.clr_mask = 4'hf; step();
    idle(); bus.irq_en = 4'b0010; bus.irq_ack = 1; step();
    bus.irq_ack = 0; bus.req_valid = 2'b01; bus.req_flags0 = 4'b0010; step();
    chk("irq_n1", bus.irq, 0);
    idle(); step();
    chk("irq_n2", bus.irq, 1);
    bus.irq_en = 4'b0000; step(); step();
    chk("irq_hold", bus.irq, 1);
    bus.irq_en = 4'b0010; bus.irq_ack = 1; step();
    chk("irq_acked", bus.irq, 0);
    idle(); step();
    bus.clr_valid = 1; bus.clr_mask = 4'b0010; step();
    idle(); step(); step();
    bus.req_valid = 2'b01; bus.req_flags0 = 4'b0010; step();
    idle(); step();
    chk("irq_rearm", bus.irq, 1);
    bus.irq_ack = 1; step();
    idle(); bus.req_valid = 2'b10; bus.req_flags1 = 4'b0011; bus.irq_en = 4'b0011; step();
    idle(); step();
    chk("irq_newbit", bus.irq, 1);
    // saturation
    bus.irq_en = 0; bus.irq_ack = 1; step();
    idle();
    for (int i = 0; i < 300; i++) begin
      bus.req_valid = 2'b01; bus.req_flags0 = 4'b0001 << (i % 4); step();
    end
    bus.req_flags0 = 4'b0000; step();
    chk("sat_cnt", bus.evt_cnt, 255);
    // reset mid-operation with irq high
    bus.irq_en = 4'hf; bus.irq_ack = 0; bus.req_valid = 2'b11;
    bus.req_flags0 = 4'b0001; bus.req_flags1 = 4'b1000; step(); step(); step();
    chk("pre_rst_irq", bus.irq, 1);
    #2 reset_n = 0;
    #1;
    chk("mid_ready", bus.req_ready, 0);
    chk("mid_clr_ready", bus.clr_ready, 0);
    chk("mid_flags", bus.flags, 0);
    chk("mid_irq", bus.irq, 0);
    chk("mid_cnt", bus.evt_cnt, 0);
    m_reset();
    @(negedge clk); reset_n = 1;
    step();
    chk("post_rst_grant", bus.req_ready, 2'b10);
    step();
    idle(); step();
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
